// File: rtl/risc_cpu_sequencer.sv
// Instruction-cycle controller for the 8-bit accumulator RISC CPU: 8-phase fetch/execute
// sequencer with memory-ready stalls and a sticky stall timeout. Optional macro SEQ_SINGLE_STEP_EN.
module risc_cpu_sequencer #(
  parameter int NUM_PHASES = 8,
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    P_INST_ADDR  = 3'd0,
    P_INST_FETCH = 3'd1,
    P_INST_LOAD  = 3'd2,
    P_IDLE       = 3'd3,
    P_OP_ADDR    = 3'd4,
    P_OP_FETCH   = 3'd5,
    P_ALU_OP     = 3'd6,
    P_STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);
  localparam logic [3:0] WAIT_MAX   = 4'(WAIT_LIMIT);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_e     phase_q, phase_d;
  logic       halted_q, halted_d;
  logic [3:0] stall_cnt_q, stall_cnt_d;
  logic       err_timeout_q, err_timeout_d;

  logic alu_op, is_sto, mem_phase, advance, step_go;

  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_sto = (opcode == OP_STO);

  // Only phases that actually touch memory may stall on mem_ready.
  assign mem_phase = (phase_q == P_INST_FETCH) ||
                     ((phase_q == P_OP_FETCH) && alu_op) ||
                     ((phase_q == P_STORE) && is_sto);

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q, step_d;
  logic step_pending_q, step_pending_d;

  assign step_go = step_pending_q;

  always_comb begin
    step_d         = step;
    step_pending_d = step_pending_q | (step & ~step_q);
    if ((phase_q == P_INST_ADDR) && advance) step_pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q         <= 1'b0;
      step_pending_q <= 1'b0;
    end else begin
      step_q         <= step_d;
      step_pending_q <= step_pending_d;
    end
  end
`else
  assign step_go = 1'b0;
`endif

  always_comb begin
    phase_d       = phase_q;
    halted_d      = halted_q;
    stall_cnt_d   = stall_cnt_q;
    err_timeout_d = err_timeout_q;
    advance       = 1'b0;
    if (!halted_q) begin
      if (phase_q == P_INST_ADDR) begin
        advance = enable | step_go;
      end else if ((phase_q == P_OP_ADDR) && (opcode == OP_HLT)) begin
        halted_d = 1'b1;
      end else if (mem_phase && !mem_ready) begin
        stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 4'd1;
        if (stall_cnt_d == WAIT_MAX) err_timeout_d = 1'b1;
      end else begin
        advance = 1'b1;
      end
      if (advance) begin
        phase_d     = (phase_q == LAST_PHASE) ? P_INST_ADDR : phase_e'(phase_q + 3'd1);
        stall_cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= P_INST_ADDR;
      halted_q      <= 1'b0;
      stall_cnt_q   <= 4'd0;
      err_timeout_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      halted_q      <= halted_d;
      stall_cnt_q   <= stall_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        P_INST_ADDR:  sel = 1'b1;
        P_INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        P_INST_LOAD, P_IDLE: begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        P_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        P_OP_FETCH: rd = alu_op;
        P_ALU_OP: begin
          rd     = alu_op;
          data_e = is_sto;
        end
        P_STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          wr     = is_sto;
          data_e = is_sto;
        end
        default: sel = 1'b1;
      endcase
    end
  end

  assign phase       = phase_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: doc/risc_cpu_sequencer.md
Name: risc_cpu_sequencer

Overview:
- Instruction-cycle controller for the 8-bit accumulator RISC CPU.
- Runs an 8-phase fetch/execute sequence per instruction.
- Generates the load strobes for the instruction register, accumulator and PC, the address-mux select, and the memory read/write/data-enable controls.
- Consumes the instruction register's 3-bit opcode field and the ALU zero flag; stalls on a memory-ready handshake.

Parameters:
- NUM_PHASES, 8, phases per instruction; fixed; phase counter width is 3.
- WAIT_LIMIT, 15, max consecutive mem_ready-low stall cycles before err_timeout asserts; 4-bit stall counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; forces phase 0, clears halt, stall count and error.
- enable  input  1  run enable; sampled only in phase 0.
- opcode  input  3  IR opcode: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7.
- zero  input  1  accumulator-zero flag.
- mem_ready  input  1  memory completes the current read/write this cycle.
- sel  output  1  address mux: 1=PC, 0=IR operand.
- rd  output  1  memory read.
- wr  output  1  memory write.
- ld_ir  output  1  instruction register load.
- ld_ac  output  1  accumulator load.
- inc_pc  output  1  PC increment.
- ld_pc  output  1  PC load from IR operand.
- data_e  output  1  drive accumulator onto data bus.
- halt  output  1  CPU halted.
- phase  output  3  current phase, for debug.
- err_timeout  output  1  sticky: memory stall exceeded WAIT_LIMIT.

Behaviour:
- Registered state: phase[2:0], halted, stall_cnt[3:0], err_timeout. Outputs are a combinational decode of (phase, halted, opcode, zero).
- Reset (async, any time, including mid-instruction or mid-stall): phase=0, halted=0, stall_cnt=0, err_timeout=0. All strobes immediately 0 except sel=1.
- ALUOP = opcode is ADD, AND, XOR or LDA.
- Phase decode (unlisted outputs are 0):
  - P0 INST_ADDR: sel=1.
  - P1 INST_FETCH: sel=1, rd=1.
  - P2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - P3 IDLE: sel=1, rd=1, ld_ir=1.
  - P4 OP_ADDR: inc_pc=1 (exactly one cycle); halt=1 if opcode==HLT.
  - P5 OP_FETCH: rd=ALUOP.
  - P6 ALU_OP: rd=ALUOP; data_e=(STO).
  - P7 STORE: rd=ALUOP; ld_ac=ALUOP; inc_pc=(SKZ && zero); ld_pc=(JMP); wr=(STO); data_e=(STO).
- Transitions:
  - P0->P1 only if enable=1; otherwise hold P0.
  - P1 and P5 (P5 only when rd=1) and P7 (only when wr=1) are memory phases. A memory phase with mem_ready=0 holds its phase and outputs and increments stall_cnt. mem_ready=1 advances and clears stall_cnt.
  - All other phases advance unconditionally. P7->P0 wraps.
  - P4 with opcode==HLT: enter halted at the next edge. In halted, phase reads 4, halt=1 and all other strobes are 0. Exit only via reset; enable is ignored.
- Timeout: when stall_cnt reaches WAIT_LIMIT, err_timeout sets (sticky until reset) and the FSM keeps waiting. stall_cnt saturates at 15.
- Latency: 8 cycles per instruction with zero wait states, plus one cycle per stall cycle.
- ld_ir is high in P2 and P3, so the IR opcode is valid from P4. opcode is ignored in P0–P3.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined: adds input step (1 bit). A registered rising-edge detect of step sets step_pending. In P0 the FSM advances if enable=1 or step_pending=1. Leaving P0 clears step_pending, so exactly one instruction executes per step pulse while enable=0. reset clears step_pending.
- Undefined: no step port, no step logic; P0 advances on enable only.

Test Plan:
- reset, enable=1, mem_ready=1, opcode=LDA (5) -> phase cycles 0..7. ld_ir high in P2 and P3; inc_pc high P4 only; ld_ac high P7 only; 8 cycles per instruction.
- opcode=STO (6), mem_ready low 3 cycles in P7 -> data_e high P6–P7; wr held high 4 cycles; phase stays 7 for 3 extra cycles; err_timeout=0.
- opcode=SKZ (1), zero=1 then zero=0 -> inc_pc pulses in P4 and P7 in the first case; P4 only in the second. opcode=JMP (7) -> ld_pc=1 in P7 only.
- opcode=HLT (0) -> halt=1 from P4 onward and remains 1 after 20 cycles with enable=1; other strobes 0. Pulse reset -> phase=0, halt=0.
- mem_ready=0 held in P1 for 16 cycles -> err_timeout=1 from the cycle stall_cnt hits 15 and stays 1. mem_ready=1 -> advances to P2. Assert reset mid-stall -> all cleared asynchronously.
- SEQ_SINGLE_STEP_EN defined, enable=0 -> FSM holds P0. A single step pulse -> exactly one 8-phase instruction, then holds P0 again.
